player_box_drawer: RTL and testbench

- Renders the running-man player box into the VGA frame buffer. It is the consumer/reader end of the vertical-position interface that the y-position counter drives.
- On each frame `update` tick it samples the player y and erases the box at the previously drawn y (background colour). It then draws the box at the new y (player colour), one pixel per clock.
- It sits between the y-position logic and the VGA adapter's plot/x/y/colour write port.

---
 rtl/player_box_drawer.sv | 164 ++++++++++++++++
 tb/tb_player_box_drawer.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/player_box_drawer.sv
// Player box renderer: on each accepted frame tick, erases the box at the previously
// drawn row, then draws it at the newly sampled row, writing one pixel per clock.
module player_box_drawer #(
    parameter int         X_POS     = 20,
    parameter int         BOX_W     = 4,
    parameter int         BOX_H     = 8,
    parameter int         SCREEN_H  = 120,
    parameter logic [2:0] FG_COLOUR = 3'b111,
    parameter logic [2:0] BG_COLOUR = 3'b000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       update,
    input  logic [6:0] y_in,
    output logic       plot,
    output logic [7:0] plot_x,
    output logic [6:0] plot_y,
    output logic [2:0] colour,
    output logic       busy,
    output logic       done
);

    // Handshake: update is accepted only on a clock edge where busy is low. busy stays high
    // from the first pixel cycle through the done cycle. Updates that arrive while busy is
    // high are dropped, not queued.
    typedef enum logic [1:0] {IDLE, ERASE, DRAW, FINISH} state_t;

    state_t     state, state_n;
    logic [2:0] px, px_n;
    logic [3:0] py, py_n;
    logic [6:0] new_y, new_y_n;
    logic [6:0] old_y, old_y_n;
    logic       drawn_valid, drawn_valid_n;

    logic       plot_n, busy_n, done_n;
    logic [7:0] plot_x_n;
    logic [6:0] plot_y_n;
    logic [2:0] colour_n;

    logic       emit;
    logic [6:0] base_y;
    logic [2:0] pix_colour;
    logic [7:0] row_sum;
    logic       last_px, last_py;

    assign last_px = (px == 3'(BOX_W - 1));
    assign last_py = (py == 4'(BOX_H - 1));

    always_comb begin
        state_n       = state;
        px_n          = px;
        py_n          = py;
        new_y_n       = new_y;
        old_y_n       = old_y;
        drawn_valid_n = drawn_valid;
        emit          = 1'b0;
        base_y        = new_y;
        pix_colour    = colour;
        busy_n        = 1'b0;
        done_n        = 1'b0;
        plot_n        = 1'b0;
        plot_x_n      = plot_x;
        plot_y_n      = plot_y;
        colour_n      = colour;
        row_sum       = 8'd0;

        case (state)
            IDLE: begin
                if (update) begin
                    new_y_n = y_in;
                    px_n    = 3'd0;
                    py_n    = 4'd0;
                    if (drawn_valid && (y_in == old_y)) begin
                        state_n = FINISH;
                        busy_n  = 1'b1;
                        done_n  = 1'b1;
                    end else if (drawn_valid) begin
                        state_n    = ERASE;
                        emit       = 1'b1;
                        base_y     = old_y;
                        pix_colour = BG_COLOUR;
                    end else begin
                        state_n    = DRAW;
                        emit       = 1'b1;
                        base_y     = y_in;
                        pix_colour = FG_COLOUR;
                    end
                end
            end
            ERASE, DRAW: begin
                if (last_px && last_py) begin
                    px_n = 3'd0;
                    py_n = 4'd0;
                    if (state == ERASE) begin
                        state_n    = DRAW;
                        emit       = 1'b1;
                        base_y     = new_y;
                        pix_colour = FG_COLOUR;
                    end else begin
                        state_n       = FINISH;
                        old_y_n       = new_y;
                        drawn_valid_n = 1'b1;
                        busy_n        = 1'b1;
                        done_n        = 1'b1;
                    end
                end else begin
                    if (last_px) begin
                        px_n = 3'd0;
                        py_n = py + 4'd1;
                    end else begin
                        px_n = px + 3'd1;
                    end
                    emit       = 1'b1;
                    base_y     = (state == ERASE) ? old_y : new_y;
                    pix_colour = (state == ERASE) ? BG_COLOUR : FG_COLOUR;
                end
            end
            FINISH: state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // Outputs describe the pixel selected by the next counter values, so they are
        // registered alongside the counters and appear one cycle after acceptance.
        if (emit) begin
            row_sum  = {1'b0, base_y} + {4'b0000, py_n};
            plot_n   = (row_sum < 8'(SCREEN_H));
            plot_x_n = 8'(X_POS) + {5'b00000, px_n};
            plot_y_n = row_sum[6:0];
            colour_n = pix_colour;
            busy_n   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            px          <= 3'd0;
            py          <= 4'd0;
            new_y       <= 7'd0;
            old_y       <= 7'd0;
            drawn_valid <= 1'b0;
            plot        <= 1'b0;
            plot_x      <= 8'd0;
            plot_y      <= 7'd0;
            colour      <= BG_COLOUR;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            px          <= px_n;
            py          <= py_n;
            new_y       <= new_y_n;
            old_y       <= old_y_n;
            drawn_valid <= drawn_valid_n;
            plot        <= plot_n;
            plot_x      <= plot_x_n;
            plot_y      <= plot_y_n;
            colour      <= colour_n;
            busy        <= busy_n;
            done        <= done_n;
        end
    end

endmodule

// File: tb/tb_player_box_drawer.sv
// Bench for player_box_drawer: the driver queues the expected per-cycle output of each redraw,
// and a negedge monitor pops and compares every busy cycle.
module tb_player_box_drawer;

  localparam int W = 20;  // {plot, x[7:0], y[6:0], colour[2:0], done}

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       update = 1'b0;
  logic [6:0] y_in = 7'd0;
  logic       plot, busy, done;
  logic [7:0] plot_x;
  logic [6:0] plot_y;
  logic [2:0] colour;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass = 0;
  int plot_cnt = 0;

  player_box_drawer dut (
    .clk(clk), .reset(reset), .update(update), .y_in(y_in),
    .plot(plot), .plot_x(plot_x), .plot_y(plot_y), .colour(colour),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Expected walk of one box: columns 20..23 fastest, rows base..base+7, clipped at row 120.
  task automatic push_box(input logic [6:0] base, input logic [2:0] col);
    logic [7:0] row;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 4; c++) begin
        row = {1'b0, base} + 8'(r);
        exp_q.push_back({(row < 8'd120), 8'(20 + c), row[6:0], col, 1'b0});
      end
    end
  endtask

  // Monitor: every busy cycle must match the head of the queue; idle cycles must be quiet.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (busy) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_busy_cycle", 32'(busy), 32'(1'b0));
      end else begin
        e = exp_q.pop_front();
        chk("plot", 32'(plot), 32'(e[19]));
        chk("done", 32'(done), 32'(e[0]));
        if (!e[0]) begin
          chk("plot_x", 32'(plot_x), 32'(e[18:11]));
          chk("plot_y", 32'(plot_y), 32'(e[10:4]));
          chk("colour", 32'(colour), 32'(e[3:1]));
        end
      end
    end else if (!reset) begin
      chk("idle_quiet", 32'({plot, done}), 32'(2'b00));
    end
    if (plot) plot_cnt++;
  end

  // mode: 0 draw only, 1 erase old_y then draw, 2 same row (no pixels)
  task automatic run_frame(input string name, input logic [6:0] y, input int mode,
                           input logic [6:0] oy, input int exp_lat, input int exp_plots,
                           input int disturb_cyc, input int reset_cyc);
    int cyc;
    bit seen_done;
    if (mode == 1) push_box(oy, 3'b000);
    if (mode != 2) push_box(y, 3'b111);
    exp_q.push_back({1'b0, 8'd0, 7'd0, 3'd0, 1'b1});
    plot_cnt = 0;
    seen_done = 0;
    @(negedge clk);
    update = 1'b1;
    y_in = y;
    @(negedge clk);
    update = 1'b0;
    cyc = 1;
    while (cyc <= 200) begin
      if (cyc == 2) y_in = 7'($urandom_range(0, 127));
      if (cyc == disturb_cyc) begin
        update = 1'b1;
        y_in = 7'd77;
      end else begin
        update = 1'b0;
      end
      if (cyc == reset_cyc) begin
        #2 reset = 1'b1;
        #1;
        chk({name, "_reset_plot"}, 32'(plot), 32'(1'b0));
        chk({name, "_reset_busy"}, 32'(busy), 32'(1'b0));
        chk({name, "_reset_done"}, 32'(done), 32'(1'b0));
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        break;
      end
      if (done) begin
        seen_done = 1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    update = 1'b0;
    #1;
    if (reset_cyc == 0) begin
      chk({name, "_done_seen"}, 32'(seen_done), 32'(1'b1));
      chk({name, "_done_latency"}, 32'(cyc), 32'(exp_lat));
      chk({name, "_plot_count"}, 32'(plot_cnt), 32'(exp_plots));
      chk({name, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_plot", 32'(plot), 32'(1'b0));
    chk("rst_xy", 32'({plot_x, plot_y}), 32'd0);
    chk("rst_colour", 32'(colour), 32'(3'b000));
    chk("rst_busy_done", 32'({busy, done}), 32'(2'b00));
    reset = 1'b0;
    repeat (2) @(negedge clk);

    run_frame("first_draw_108", 7'd108, 0, 7'd0,   33, 32, 0, 0);
    run_frame("move_to_99",     7'd99,  1, 7'd108, 65, 64, 0, 0);
    run_frame("same_99",        7'd99,  2, 7'd99,  1,  0,  0, 0);
    run_frame("clip_116",       7'd116, 1, 7'd99,  65, 48, 0, 0);
    run_frame("disturbed_30",   7'd30,  1, 7'd116, 65, 48, 42, 0);
    run_frame("reset_mid_60",   7'd60,  1, 7'd30,  0,  0,  0, 37);
    run_frame("after_reset_50", 7'd50,  0, 7'd0,   33, 32, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
